// File: rtl/fl_mark_extract_if.sv
// FrameLink link: a beat transfers when src_rdy_n and dst_rdy_n are both low.
interface fl_mark_extract_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int REM_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

    logic [DATA_WIDTH-1:0] data;
    logic [REM_WIDTH-1:0]  rem;
    logic                  sof_n;
    logic                  eof_n;
    logic                  sop_n;
    logic                  eop_n;
    logic                  src_rdy_n;
    logic                  dst_rdy_n;

    modport master (output data, rem, sof_n, eof_n, sop_n, eop_n, src_rdy_n, input dst_rdy_n);
    modport slave  (input data, rem, sof_n, eof_n, sop_n, eop_n, src_rdy_n, output dst_rdy_n);
endinterface

// File: rtl/fl_mark_extract.sv
// Pulls a SIZE-word mark out of each frame header at word OFFSET and presents it on a
// separate valid/ready port; all other words pass through with zero latency.
module fl_mark_extract #(
    parameter int DATA_WIDTH = 32,
    parameter int OFFSET     = 0,
    parameter int SIZE       = 1,
    parameter bit REMOVE     = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    fl_mark_extract_if.slave           rx,
    fl_mark_extract_if.master          tx,
    output logic [SIZE*DATA_WIDTH-1:0] mark,
    output logic                       mark_vld,
    output logic                       mark_err,
    input  logic                       mark_rdy
);
    localparam int CNT_MAX = (OFFSET > SIZE) ? OFFSET : SIZE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, PRE, MARK, PASS} state_t;

    state_t                     state;
    state_t                     state_next;
    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           cnt_next;
    logic [CNT_W-1:0]           mark_idx;
    logic                       pend_sof;
    logic                       pend_sop;
    logic [SIZE*DATA_WIDTH-1:0] mark_next;
    logic                       mark_free;
    logic                       is_sof;
    logic                       is_eof;
    logic                       in_mark;
    logic                       short_hdr;
    logic                       drop;
    logic                       gate;
    logic                       rx_xfer;
    logic                       capture;
    logic                       mark_done;

    // With OFFSET=0 the SOF word itself is mark word 0, so it is classified before the FSM moves.
    assign mark_free = !mark_vld || mark_rdy;
    assign is_sof    = !rx.sof_n;
    assign is_eof    = !rx.eof_n;
    assign in_mark   = (state == MARK) || ((state == IDLE) && is_sof && (OFFSET == 0));
    assign mark_idx  = (state == MARK) ? cnt : '0;
    assign short_hdr = in_mark && (!rx.eop_n || is_eof);
    assign drop      = in_mark && REMOVE && !short_hdr;
    assign gate      = in_mark && !mark_free;
    assign rx_xfer   = !rx.src_rdy_n && !rx.dst_rdy_n;
    assign capture   = rx_xfer && in_mark;
    assign mark_done = capture && (short_hdr || (mark_idx == CNT_W'(SIZE - 1)));

    always_comb begin
        tx.data  = rx.data;
        tx.rem   = rx.rem;
        tx.eof_n = rx.eof_n;
        tx.eop_n = rx.eop_n;
        tx.sof_n = rx.sof_n & ~pend_sof;
        tx.sop_n = rx.sop_n & ~pend_sop;
        if (!reset_n) begin
            tx.src_rdy_n = 1'b1;
            rx.dst_rdy_n = 1'b1;
        end else if (drop) begin
            tx.src_rdy_n = 1'b1;
            rx.dst_rdy_n = !mark_free;
        end else begin
            tx.src_rdy_n = rx.src_rdy_n | gate;
            rx.dst_rdy_n = tx.dst_rdy_n | gate;
        end
    end

    // OFFSET=1 goes straight to MARK: the SOF word already is the single header word to skip.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (rx_xfer) begin
            case (state)
                IDLE: begin
                    if (is_sof) begin
                        if (OFFSET == 0) begin
                            if (mark_done) begin
                                state_next = PASS;
                            end else begin
                                state_next = MARK;
                                cnt_next   = CNT_W'(1);
                            end
                        end else if (OFFSET == 1) begin
                            state_next = MARK;
                            cnt_next   = '0;
                        end else begin
                            state_next = PRE;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                end
                PRE: begin
                    if (cnt == CNT_W'(OFFSET - 1)) begin
                        state_next = MARK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                MARK: begin
                    if (mark_done) begin
                        state_next = PASS;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
            if (is_eof) begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        end
    end

    // Word 0 wipes the other slices so a truncated mark reads back as zeros.
    always_comb begin
        mark_next = (mark_idx == '0) ? '0 : mark;
        for (int k = 0; k < SIZE; k++) begin
            if (mark_idx == CNT_W'(k)) begin
                mark_next[k*DATA_WIDTH +: DATA_WIDTH] = rx.data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_sof <= 1'b0;
            pend_sop <= 1'b0;
            mark     <= '0;
            mark_vld <= 1'b0;
            mark_err <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                mark <= mark_next;
            end
            if (mark_done) begin
                mark_vld <= 1'b1;
                mark_err <= short_hdr;
            end else if (mark_vld && mark_rdy) begin
                mark_vld <= 1'b0;
                mark_err <= 1'b0;
            end
            if (rx_xfer) begin
                if (drop) begin
                    pend_sof <= pend_sof | is_sof;
                    pend_sop <= pend_sop | !rx.sop_n;
                end else begin
                    pend_sof <= 1'b0;
                    pend_sop <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fl_mark_extract.sv
// Scoreboard bench: stimulus queues expected TX words, marks and signal probes; one
// negedge monitor compares them against three DUT variants selected by 'sel'.
`timescale 1ns/1ps
module tb_fl_mark_extract;
    localparam int DW = 32;
    localparam int SZ = 2;

    typedef logic [37:0] word_t;
    typedef enum int {P_RXRDY, P_TXSRC, P_VLD, P_ERR, P_MARK, P_TIMEOUT} pkind_t;
    typedef struct {
        pkind_t      kind;
        logic [63:0] exp;
    } probe_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  sel;
    word_t       drv_word;
    logic        drv_src_rdy_n;
    logic        drv_mark_rdy;
    logic        toggle_en;
    logic        phase = 1'b0;
    logic        done;
    wire         drv_tx_dst_rdy_n = toggle_en & phase;

    word_t       tx_word  [3];
    logic        tx_src_n [3];
    logic        rx_dst_n [3];
    logic        vld      [3];
    logic        err      [3];
    logic [63:0] mk       [3];

    word_t       tx_q[$];
    logic [64:0] mark_q[$];
    probe_t      probe_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    probe_t      mon_p;
    word_t       mon_w;
    logic [64:0] mon_m;
    word_t       fa[6];

    always #5 clk = ~clk;
    always @(posedge clk) phase <= ~phase;

    // Variant 0: OFFSET=0 remove; 1: OFFSET=1 remove; 2: OFFSET=1 forward.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        fl_mark_extract_if #(.DATA_WIDTH(DW)) rx();
        fl_mark_extract_if #(.DATA_WIDTH(DW)) tx();
        logic mrdy;
        logic [SZ*DW-1:0] mark;
        assign rx.data      = drv_word[31:0];
        assign rx.rem       = drv_word[37:36];
        assign rx.sof_n     = drv_word[35];
        assign rx.sop_n     = drv_word[34];
        assign rx.eop_n     = drv_word[33];
        assign rx.eof_n     = drv_word[32];
        assign rx.src_rdy_n = (sel == 2'(g)) ? drv_src_rdy_n : 1'b1;
        assign tx.dst_rdy_n = (sel == 2'(g)) ? drv_tx_dst_rdy_n : 1'b1;
        assign mrdy         = (sel == 2'(g)) ? drv_mark_rdy : 1'b0;
        assign tx_word[g]   = {tx.rem, tx.sof_n, tx.sop_n, tx.eop_n, tx.eof_n, tx.data};
        assign tx_src_n[g]  = tx.src_rdy_n;
        assign rx_dst_n[g]  = rx.dst_rdy_n;
        assign mk[g]        = mark;

        fl_mark_extract #(
            .DATA_WIDTH(DW),
            .OFFSET((g == 0) ? 0 : 1),
            .SIZE(SZ),
            .REMOVE(g != 2)
        ) u_dut (
            .clk(clk),
            .reset_n(reset_n),
            .rx(rx),
            .tx(tx),
            .mark(mark),
            .mark_vld(vld[g]),
            .mark_err(err[g]),
            .mark_rdy(mrdy)
        );
    end

    function automatic word_t fw(input logic [31:0] d, input logic sof, input logic sop,
                                 input logic eop, input logic eof, input logic [1:0] rem);
        return {rem, ~sof, ~sop, ~eop, ~eof, d};
    endfunction

    function automatic string pname(input pkind_t k);
        case (k)
            P_RXRDY: return "rx_dst_rdy_n";
            P_TXSRC: return "tx_src_rdy_n";
            P_VLD:   return "mark_vld";
            P_ERR:   return "mark_err";
            P_MARK:  return "mark";
            default: return "rx_timeout";
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Single checking process: probes, TX scoreboard, mark scoreboard, and final summary.
    always @(negedge clk) begin
        while (probe_q.size() > 0) begin
            mon_p = probe_q.pop_front();
            case (mon_p.kind)
                P_RXRDY: checkOutput(pname(mon_p.kind), 64'(rx_dst_n[sel]), mon_p.exp);
                P_TXSRC: checkOutput(pname(mon_p.kind), 64'(tx_src_n[sel]), mon_p.exp);
                P_VLD:   checkOutput(pname(mon_p.kind), 64'(vld[sel]), mon_p.exp);
                P_ERR:   checkOutput(pname(mon_p.kind), 64'(err[sel]), mon_p.exp);
                P_MARK:  checkOutput(pname(mon_p.kind), mk[sel], mon_p.exp);
                default: begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL rx_timeout: word %h not accepted, required accept", drv_word);
                end
            endcase
        end
        if (reset_n && !tx_src_n[sel] && !drv_tx_dst_rdy_n) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL tx_unexpected: got %h, want no beat", tx_word[sel]);
            end else begin
                mon_w = tx_q.pop_front();
                checkOutput("tx_word", 64'(tx_word[sel]), 64'(mon_w));
            end
        end
        if (reset_n && vld[sel] && drv_mark_rdy) begin
            if (mark_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL mark_unexpected: got %h, want no mark", mk[sel]);
            end else begin
                mon_m = mark_q.pop_front();
                checkOutput("mark_value", mk[sel], mon_m[63:0]);
                checkOutput("mark_err_flag", 64'(err[sel]), 64'(mon_m[64]));
            end
        end
        if (done) begin
            checkOutput("tx_queue_left", 64'(tx_q.size()), 64'd0);
            checkOutput("mark_queue_left", 64'(mark_q.size()), 64'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic probe(input pkind_t k, input logic [63:0] e);
        probe_t p;
        p.kind = k;
        p.exp  = e;
        probe_q.push_back(p);
    endtask

    task automatic applyStimulus(input word_t w);
        int   t;
        logic acc;
        t   = 0;
        acc = 1'b0;
        drv_word      = w;
        drv_src_rdy_n = 1'b0;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = !rx_dst_n[sel];
            @(posedge clk);
            #1;
            t++;
        end
        drv_src_rdy_n = 1'b1;
        if (!acc) probe(P_TIMEOUT, 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Standard frame with the mark taken at OFFSET=1 and removed from TX.
    task automatic frameOffset1(input logic [64:0] exp_mark);
        tx_q.push_back(fa[0]);
        tx_q.push_back(fa[3]);
        tx_q.push_back(fa[4]);
        tx_q.push_back(fa[5]);
        mark_q.push_back(exp_mark);
        applyStimulus(fa[0]);
        applyStimulus(fa[1]);
        applyStimulus(fa[2]);
        probe(P_VLD, 64'd1);
        applyStimulus(fa[3]);
        applyStimulus(fa[4]);
        applyStimulus(fa[5]);
    endtask

    initial begin
        fa[0] = fw(32'h11111111, 1, 1, 0, 0, 2'd0);
        fa[1] = fw(32'h22222222, 0, 0, 0, 0, 2'd0);
        fa[2] = fw(32'h33333333, 0, 0, 0, 0, 2'd0);
        fa[3] = fw(32'h44444444, 0, 0, 1, 0, 2'd0);
        fa[4] = fw(32'h000000AA, 0, 0, 0, 0, 2'd0);
        fa[5] = fw(32'h000000BB, 0, 0, 1, 1, 2'd1);
        reset_n       = 1'b0;
        sel           = 2'd1;
        drv_word      = fa[0];
        drv_src_rdy_n = 1'b0;
        drv_mark_rdy  = 1'b1;
        toggle_en     = 1'b0;
        done          = 1'b0;

        $display("[TB] reset state");
        probe(P_TXSRC, 64'd1);
        probe(P_RXRDY, 64'd1);
        probe(P_VLD, 64'd0);
        probe(P_ERR, 64'd0);
        probe(P_MARK, 64'd0);
        idle(2);
        drv_src_rdy_n = 1'b1;
        reset_n = 1'b1;
        idle(2);

        $display("[TB] non-SOF word in IDLE passes through");
        tx_q.push_back(fw(32'h55555555, 0, 0, 0, 0, 2'd2));
        applyStimulus(fw(32'h55555555, 0, 0, 0, 0, 2'd2));
        probe(P_VLD, 64'd0);
        idle(3);

        $display("[TB] OFFSET=1 mark removed");
        frameOffset1({1'b0, 64'h33333333_22222222});
        idle(4);

        $display("[TB] OFFSET=0 pending SOF/SOP");
        sel = 2'd0;
        tx_q.push_back(fw(32'h33333333, 1, 1, 0, 0, 2'd0));
        tx_q.push_back(fa[3]);
        tx_q.push_back(fa[4]);
        tx_q.push_back(fa[5]);
        mark_q.push_back({1'b0, 64'h22222222_11111111});
        applyStimulus(fa[0]);
        applyStimulus(fa[1]);
        probe(P_VLD, 64'd1);
        probe(P_ERR, 64'd0);
        for (int i = 2; i < 6; i++) applyStimulus(fa[i]);
        idle(4);

        $display("[TB] OFFSET=0 short header carries pending flags");
        tx_q.push_back(fw(32'h22222222, 1, 1, 1, 0, 2'd0));
        tx_q.push_back(fa[5]);
        mark_q.push_back({1'b1, 64'h22222222_11111111});
        applyStimulus(fa[0]);
        applyStimulus(fw(32'h22222222, 0, 0, 1, 0, 2'd0));
        probe(P_VLD, 64'd1);
        probe(P_ERR, 64'd1);
        applyStimulus(fa[5]);
        idle(4);

        $display("[TB] OFFSET=1 short header");
        sel = 2'd1;
        tx_q.push_back(fa[0]);
        tx_q.push_back(fw(32'h22222222, 0, 0, 1, 0, 2'd0));
        tx_q.push_back(fa[4]);
        tx_q.push_back(fa[5]);
        mark_q.push_back({1'b1, 64'h00000000_22222222});
        applyStimulus(fa[0]);
        applyStimulus(fw(32'h22222222, 0, 0, 1, 0, 2'd0));
        probe(P_VLD, 64'd1);
        probe(P_ERR, 64'd1);
        applyStimulus(fa[4]);
        applyStimulus(fa[5]);
        idle(4);

        $display("[TB] TX backpressure toggling");
        toggle_en = 1'b1;
        frameOffset1({1'b0, 64'h33333333_22222222});
        toggle_en = 1'b0;
        idle(4);

        $display("[TB] mark register busy stalls next frame");
        drv_mark_rdy = 1'b0;
        frameOffset1({1'b0, 64'h33333333_22222222});
        tx_q.push_back(fa[0]);
        tx_q.push_back(fa[3]);
        tx_q.push_back(fa[4]);
        tx_q.push_back(fa[5]);
        mark_q.push_back({1'b0, 64'h33333333_22222222});
        applyStimulus(fa[0]);
        drv_word      = fa[1];
        drv_src_rdy_n = 1'b0;
        repeat (3) begin
            probe(P_RXRDY, 64'd1);
            probe(P_MARK, 64'h33333333_22222222);
            probe(P_VLD, 64'd1);
            idle(1);
        end
        drv_mark_rdy = 1'b1;
        probe(P_RXRDY, 64'd0);
        idle(1);
        drv_mark_rdy = 1'b0;
        applyStimulus(fa[2]);
        probe(P_VLD, 64'd1);
        applyStimulus(fa[3]);
        applyStimulus(fa[4]);
        applyStimulus(fa[5]);
        idle(2);
        drv_mark_rdy = 1'b1;
        idle(4);

        $display("[TB] reset during mark capture");
        tx_q.push_back(fa[0]);
        applyStimulus(fa[0]);
        applyStimulus(fa[1]);
        reset_n = 1'b0;
        probe(P_VLD, 64'd0);
        probe(P_MARK, 64'd0);
        idle(2);
        reset_n = 1'b1;
        probe(P_VLD, 64'd0);
        idle(2);
        frameOffset1({1'b0, 64'h33333333_22222222});
        idle(4);

        $display("[TB] REMOVE=0 forwards mark words");
        sel = 2'd2;
        for (int i = 0; i < 6; i++) tx_q.push_back(fa[i]);
        mark_q.push_back({1'b0, 64'h33333333_22222222});
        applyStimulus(fa[0]);
        applyStimulus(fa[1]);
        applyStimulus(fa[2]);
        probe(P_VLD, 64'd1);
        for (int i = 3; i < 6; i++) applyStimulus(fa[i]);
        idle(4);

        done = 1'b1;
    end
endmodule
